// File: rtl/counter_timer_capture_wb.sv
// Input-capture unit: snapshots {count_hi, count_lo} into a FIFO on selected event_in edges (and optionally stop_in rise).
// Latency: event_in to push is 3 clocks (2-flop sync plus edge register); stop_in to push is 1 clock; irq follows state by 1 clock.
// Backpressure: none on capture; a push into a full FIFO is dropped and sets sticky overflow. Build with CAPTURE_STOP_EN for stop_in capture.
module counter_timer_capture_wb #(
  parameter logic [31:0] BASE_ADR = 32'h2400_0100,
  parameter int          DEPTH    = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] count_lo,
  input  logic [31:0] count_hi,
  input  logic        stop_in,
  input  logic        event_in,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] ADR_CFG = BASE_ADR | 32'h0000_0000;
  localparam logic [31:0] ADR_STS = BASE_ADR | 32'h0000_0004;
  localparam logic [31:0] ADR_LO  = BASE_ADR | 32'h0000_0008;
  localparam logic [31:0] ADR_HI  = BASE_ADR | 32'h0000_000C;

  logic          r_enable, r_irq_ena, r_ovf;
  logic [1:0]    r_edge;
  logic          r_s1, r_s2, r_s3;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_lo [DEPTH];
  logic [31:0]   r_mem_hi [DEPTH];

  logic w_valid, w_sel_cfg, w_sel_sts, w_sel_lo, w_sel_hi;
  logic w_wr, w_cfg_wr, w_flush, w_ovf_clr;
  logic w_empty, w_full, w_pop, w_rise, w_fall;
  logic w_stop_cap, w_stop_src, w_push, w_push_ok, w_drop;

  assign w_valid   = wb_stb_i & wb_cyc_i;
  assign w_sel_cfg = w_valid & (wb_adr_i == ADR_CFG);
  assign w_sel_sts = w_valid & (wb_adr_i == ADR_STS);
  assign w_sel_lo  = w_valid & (wb_adr_i == ADR_LO);
  assign w_sel_hi  = w_valid & (wb_adr_i == ADR_HI);
  assign wb_ack_o  = w_sel_cfg | w_sel_sts | w_sel_lo | w_sel_hi;

  // All register writes act on byte lane 0 only
  assign w_wr      = wb_we_i & wb_sel_i[0];
  assign w_cfg_wr  = w_wr & w_sel_cfg;
  assign w_flush   = w_cfg_wr & wb_dat_i[4];
  assign w_ovf_clr = w_wr & w_sel_sts & wb_dat_i[2];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // Only a CAPHI read pops, and never from an empty FIFO
  assign w_pop   = w_sel_hi & ~wb_we_i & ~w_empty;
  assign w_rise  = r_s2 & ~r_s3;
  assign w_fall  = ~r_s2 & r_s3;

`ifdef CAPTURE_STOP_EN
  logic r_stop_src, r_stop_d;
  logic w_unused;
  assign w_stop_src = r_stop_src;
  assign w_stop_cap = r_stop_src & stop_in & ~r_stop_d;
  assign w_unused   = &{1'b0, wb_dat_i[31:6], wb_sel_i[3:1]};

  // stop_src config bit and one-register rise detector on stop_in
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_stop_src <= 1'b0;
      r_stop_d   <= 1'b0;
    end else begin
      r_stop_d <= stop_in;
      if (w_cfg_wr) r_stop_src <= wb_dat_i[5];
    end
  end
`else
  logic w_unused;
  assign w_stop_src = 1'b0;
  assign w_stop_cap = 1'b0;
  assign w_unused   = &{1'b0, wb_dat_i[31:5], wb_sel_i[3:1], stop_in};
`endif

  assign w_push    = r_enable & ((r_edge[0] & w_rise) | (r_edge[1] & w_fall) | w_stop_cap);
  // A coincident pop frees the slot, so a full FIFO still accepts the push
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  // Configuration register; flush is a pulse and is not stored
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_enable  <= 1'b0;
      r_edge    <= 2'b00;
      r_irq_ena <= 1'b0;
    end else if (w_cfg_wr) begin
      r_enable  <= wb_dat_i[0];
      r_edge    <= wb_dat_i[2:1];
      r_irq_ena <= wb_dat_i[3];
    end
  end

  // Event pin synchronizer plus edge-history flop
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= event_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // FIFO pointers, occupancy and sticky overflow; flush wins over push/pop
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Timestamp storage; contents need no reset since pointers guard reads
  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok && !w_flush && !wb_rst_i) begin
      r_mem_lo[r_wptr] <= count_lo;
      r_mem_hi[r_wptr] <= count_hi;
    end
  end

  // Interrupt registered from the current-state flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq <= 1'b0;
    else          irq <= r_irq_ena & (~w_empty | r_ovf);
  end

  // Read data mux; unmapped addresses and empty-FIFO head reads return 0
  always_comb begin
    wb_dat_o = 32'd0;
    if (w_sel_cfg)
      wb_dat_o = {26'd0, w_stop_src, 1'b0, r_irq_ena, r_edge, r_enable};
    else if (w_sel_sts)
      wb_dat_o = {24'd0, 4'(r_count), 1'b0, r_ovf, w_full, w_empty};
    else if (w_sel_lo && !w_empty)
      wb_dat_o = r_mem_lo[r_rptr];
    else if (w_sel_hi && !w_empty)
      wb_dat_o = r_mem_hi[r_rptr];
  end

endmodule
